llr_frame_loader: RTL
=====================

// Module: llr_frame_loader
// PURPOSE
// - Upstream stage of the LDPC decoder: accepts channel soft values one per cycle over a valid/ready stream.
// - Quantizes each value to a saturated signed LLR_W-bit LLR and assembles a full N-entry codeword frame.
// - Presents the frame to the decoder as one flat parallel bus, held stable until the decoder acknowledges it.
// PARAMETERS
// - N        198  LLRs per codeword (decoder input count)
// - IN_W     12   width of signed two's-complement channel sample
// - IN_FRAC  4    fractional bits of the channel sample
// - LLR_W    8    width of signed LLR delivered to the decoder
// - LLR_FRAC 2    fractional bits of the LLR; IN_FRAC >= LLR_FRAC is required
// PORTS
// - clk          in   1        clock, all state on rising edge
// - rst          in   1        asynchronous, active-low reset
// - in_valid     in   1        channel sample valid
// - in_ready     out  1        loader can accept a sample
// - in_data      in   IN_W     signed channel sample
// - in_last      in   1        marks final sample of a codeword
// - flush        in   1        synchronous abort of the partial frame
// - frame_valid  out  1        llr_out holds a complete frame
// - frame_ack    in   1        decoder has taken the frame
// - llr_out      out  N*LLR_W  frame; LLR k at bits [k*LLR_W +: LLR_W]
// - frame_err    out  1        one-cycle pulse: malformed frame dropped
// BEHAVIOUR
// - Reset (rst=0): state=FILL, cnt=0, in_ready=0 during reset then 1, frame_valid=0, frame_err=0, llr_out all 0.
// - Sample transfer: in_valid & in_ready on a rising edge.
// - Quantization:
//   - q = in_data >>> (IN_FRAC-LLR_FRAC), arithmetic shift, i.e. floor.
//   - Saturate symmetric to [-(2^(LLR_W-1)-1), +(2^(LLR_W-1)-1)]; the most negative code is never produced.
// - FSM FILL:
//   - in_ready=1.
//   - Each transfer writes q to slot cnt, then cnt++.
//   - Transfer at cnt==N-1 with in_last=1 -> HOLD.
//   - Transfer with in_last=1 at cnt<N-1, or in_last=0 at cnt==N-1 -> frame_err pulse, cnt=0, stay FILL. Written slots are not cleared.
// - FSM HOLD:
//   - in_ready=0, frame_valid=1, llr_out frozen.
//   - frame_ack=1 -> next cycle FILL, cnt=0, frame_valid=0.
//   - Entry into HOLD is registered, so frame_valid rises 1 cycle after the last transfer.
// - Latency: last sample to frame_valid is 1 cycle. frame_ack to in_ready is 1 cycle.
// - frame_ack outside HOLD is ignored.
// - flush=1:
//   - In FILL: cnt=0 next cycle, and any same-cycle transfer is discarded.
//   - In HOLD: ignored, because a completed frame is never lost.
//   - flush has priority over in_last checking. No frame_err is raised on flush.
// - in_ready depends only on state (no combinational path from frame_ack).
// - cnt width is clog2(N). cnt never exceeds N-1.
// - Mid-operation async reset discards the partial/held frame and forces reset values immediately.
// CONFIGURATION
// - LLR_SAT_STATS_EN defined:
//   - Adds output sat_cnt [15:0], the number of saturated samples in the current frame.
//   - Cleared on reset, flush, error, and on the transfer of sample 0 of a new frame.
//   - Saturating at 16'hFFFF.
//   - Valid and frozen while frame_valid=1.
// - LLR_SAT_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Quantize (defaults, shift 2), each value in a full valid frame:
//   - in 24 -> 6
//   - in -56 -> -14
//   - in -1 -> -1
//   - in 2047 -> 127
//   - in -2048 -> -127
//   - in 0 -> 0
// - Full frame:
//   - Stimulus: 198 back-to-back samples k=0..197 with in_data=k*4, in_last on k=197.
//   - Expected: frame_valid next cycle, LLR k = min(k,127), in_ready=0.
// - Hold/ack:
//   - Stimulus: delay frame_ack 10 cycles while driving in_valid=1.
//   - Expected: no transfers, llr_out stable; 1 cycle after ack, frame_valid=0, in_ready=1, cnt=0.
// - Malformed frames:
//   - in_last on sample 50 -> frame_err pulse, no frame_valid.
//   - Sample 197 without in_last -> frame_err.
//   - Next good frame decodes correctly.
// - Flush:
//   - flush after 100 samples -> no frame_err; next 198 samples form a correct frame.
//   - flush during HOLD -> frame retained until ack.
// - Reset during FILL at cnt=120 and during HOLD -> all outputs at reset values at once; a following full frame is correct.
// - With LLR_SAT_STATS_EN: frame containing 5 samples of 2047 and 3 of -2048 -> sat_cnt=8 at frame_valid.

Source files
------------

// File: rtl/llr_frame_loader.sv
// llr_frame_loader: quantizes channel soft values into saturated LLRs and
// assembles one N-entry codeword frame, presented as a flat bus held until
// the decoder acknowledges it.
// Optional build macro LLR_SAT_STATS_EN adds sat_cnt, the per-frame count of
// saturated samples.
module llr_frame_loader #(
  parameter int N        = 198,
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = 4,
  parameter int LLR_W    = 8,
  parameter int LLR_FRAC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   flush,
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic [N*LLR_W-1:0]     llr_out,
  output logic                   frame_err
`ifdef LLR_SAT_STATS_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);

  localparam int CNT_W   = $clog2(N);
  localparam int SHIFT   = IN_FRAC - LLR_FRAC;
  localparam int SAT_MAX = 2**(LLR_W-1) - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

  // Floor-shift to the LLR scale, then clamp symmetrically so the most
  // negative code never reaches the decoder.
  function automatic logic signed [LLR_W-1:0] quantize(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] sh;
    sh = x >>> SHIFT;
    if (int'(sh) > SAT_MAX)
      return LLR_W'(SAT_MAX);
    else if (int'(sh) < -SAT_MAX)
      return LLR_W'(-SAT_MAX);
    else
      return LLR_W'(sh);
  endfunction

  typedef enum logic {FILL, HOLD} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic                     err_n;
  logic                     wr_en;
  logic                     xfer;
  logic signed [LLR_W-1:0]  q;
  logic signed [LLR_W-1:0]  slot [N];

  assign xfer        = in_valid && in_ready;
  assign q           = quantize(in_data);
  assign frame_valid = (state == HOLD);

  // Next-state logic: slot write, length checking, flush and acknowledge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      FILL: begin
        if (flush) begin
          cnt_n = '0;
        end else if (xfer) begin
          wr_en = 1'b1;
          if (cnt == CNT_LAST && in_last) begin
            state_n = HOLD;
          end else if (in_last || cnt == CNT_LAST) begin
            err_n = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_n = FILL;
          cnt_n   = '0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  // Control registers; in_ready is registered so it never depends on frame_ack combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      frame_err <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_err <= err_n;
      in_ready  <= (state_n == FILL);
    end
  end

  // Frame storage; slots written by an aborted frame are simply overwritten later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) slot[k] <= '0;
    end else if (wr_en) begin
      slot[cnt] <= q;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign llr_out[k*LLR_W +: LLR_W] = slot[k];
  end

`ifdef LLR_SAT_STATS_EN
  function automatic logic saturates(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] sh;
    sh = x >>> SHIFT;
    return (int'(sh) > SAT_MAX) || (int'(sh) < -SAT_MAX);
  endfunction

  logic sat_hit;
  assign sat_hit = saturates(in_data);

  // Saturation counter: restarts with sample 0, cleared on flush/error, frozen in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (state == FILL) begin
      if (flush) begin
        sat_cnt <= '0;
      end else if (xfer) begin
        if (err_n)
          sat_cnt <= '0;
        else if (cnt == '0)
          sat_cnt <= {15'd0, sat_hit};
        else if (sat_hit && sat_cnt != 16'hFFFF)
          sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
